// File: rtl/uart_ai_pkg.sv
// Shared types and defaults for the UART RX to anomaly-core datapath.
package uart_ai_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned WIN_LEN_DEF     = 8;
    localparam int unsigned TIMEOUT_CYC_DEF = 1024;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PRESENT = 1'b1
    } win_state_e;

endpackage : uart_ai_pkg

// File: rtl/rx_window_ctrl_if.sv
// Window handshake between the RX window controller and the detector core.
interface rx_window_ctrl_if
    import uart_ai_pkg::*;
#(
    parameter int unsigned WIN_LEN = WIN_LEN_DEF
) ();

    localparam int unsigned DATA_W = WIN_LEN * BYTE_W;
    localparam int unsigned CNT_W  = $clog2(WIN_LEN + 1);

    logic [DATA_W-1:0] win_data;
    logic [CNT_W-1:0]  win_count;
    logic              win_short;
    logic              win_valid;
    logic              win_ready;

    modport master (
        output win_data,
        output win_count,
        output win_short,
        output win_valid,
        input  win_ready
    );

    modport slave (
        input  win_data,
        input  win_count,
        input  win_short,
        input  win_valid,
        output win_ready
    );

endinterface : rx_window_ctrl_if

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Count up until all-ones, then hold; clear has priority
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign o_q = r_q;

endmodule : sat_counter

// File: rtl/rx_window_ctrl.sv
// Read-side RX FIFO controller: packs popped bytes into windows for the
// anomaly core, flushes partial windows on idle timeout, counts overflow drops.
module rx_window_ctrl
    import uart_ai_pkg::*;
#(
    parameter int unsigned WIN_LEN     = WIN_LEN_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned DROP_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BYTE_W-1:0]   i_fifo_dout,
    input  logic                i_fifo_empty,
    input  logic                i_fifo_full,
    input  logic                i_rx_wr,
    output logic                o_fifo_rd_en,
    rx_window_ctrl_if.master    win_if,
    output logic [DROP_W-1:0]   o_drop_cnt
);

    localparam int unsigned DATA_W = WIN_LEN * BYTE_W;
    localparam int unsigned CNT_W  = $clog2(WIN_LEN + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC);

    win_state_e        r_state,     w_state_nxt;
    logic [CNT_W-1:0]  r_idx,       w_idx_nxt;
    logic [IDLE_W-1:0] r_idle_cnt,  w_idle_nxt;
    logic [DATA_W-1:0] r_win_data,  w_data_nxt;
    logic [CNT_W-1:0]  r_win_count, w_count_nxt;
    logic              r_win_short, w_short_nxt;
    logic              w_rd_en;
    logic              w_drop;

    // State and window registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_COLLECT;
            r_idx       <= '0;
            r_idle_cnt  <= '0;
            r_win_data  <= '0;
            r_win_count <= '0;
            r_win_short <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_idle_cnt  <= w_idle_nxt;
            r_win_data  <= w_data_nxt;
            r_win_count <= w_count_nxt;
            r_win_short <= w_short_nxt;
        end
    end

    // Next-state: collect bytes into slots, present full or timed-out windows
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_idle_nxt  = r_idle_cnt;
        w_data_nxt  = r_win_data;
        w_count_nxt = r_win_count;
        w_short_nxt = r_win_short;
        w_rd_en     = 1'b0;

        case (r_state)
            ST_COLLECT: begin
                w_rd_en = !i_fifo_empty;
                if (w_rd_en) begin
                    for (int unsigned k = 0; k < WIN_LEN; k++) begin
                        if (r_idx == CNT_W'(k)) begin
                            w_data_nxt[k*BYTE_W +: BYTE_W] = i_fifo_dout;
                        end
                    end
                    w_idx_nxt  = r_idx + CNT_W'(1);
                    w_idle_nxt = '0;
                    if (r_idx == CNT_W'(WIN_LEN - 1)) begin
                        w_state_nxt = ST_PRESENT;
                        w_count_nxt = CNT_W'(WIN_LEN);
                        w_short_nxt = 1'b0;
                    end
                end else if (r_idx != '0) begin
                    // A pop in the threshold cycle takes the branch above instead
                    if (r_idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
                        w_state_nxt = ST_PRESENT;
                        w_count_nxt = r_idx;
                        w_short_nxt = 1'b1;
                    end else begin
                        w_idle_nxt = r_idle_cnt + IDLE_W'(1);
                    end
                end else begin
                    w_idle_nxt = '0;
                end
            end

            ST_PRESENT: begin
                if (win_if.win_ready) begin
                    w_state_nxt = ST_COLLECT;
                    w_data_nxt  = '0;
                    w_idx_nxt   = '0;
                    w_idle_nxt  = '0;
                    w_short_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_COLLECT;
            end
        endcase
    end

    // Overflow: a write strobe while the FIFO is full loses that byte
    assign w_drop = i_rx_wr && i_fifo_full;

    sat_counter #(
        .W (DROP_W)
    ) u_drop_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (w_drop),
        .o_q   (o_drop_cnt)
    );

    assign o_fifo_rd_en     = w_rd_en;
    assign win_if.win_valid = (r_state == ST_PRESENT);
    assign win_if.win_data  = r_win_data;
    assign win_if.win_count = r_win_count;
    assign win_if.win_short = r_win_short;

endmodule : rx_window_ctrl

// File: tb/tb_rx_window_ctrl.sv
// Directed bench for rx_window_ctrl with a 16-deep fall-through FIFO model.
module tb_rx_window_ctrl;

    logic        clk;
    logic        rst;
    logic        rx_wr;
    logic [7:0]  wdata;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_rd_en;
    logic [15:0] drop_cnt;

    int errors;
    int checks;
    int win_seen;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    logic [7:0] mem [16];
    logic [4:0] f_cnt;
    logic [3:0] f_rd;
    logic [3:0] f_wr;

    rx_window_ctrl_if #(.WIN_LEN(4)) win_if ();

    rx_window_ctrl #(
        .WIN_LEN     (4),
        .TIMEOUT_CYC (8),
        .DROP_W      (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_fifo_dout  (fifo_dout),
        .i_fifo_empty (fifo_empty),
        .i_fifo_full  (fifo_full),
        .i_rx_wr      (rx_wr),
        .o_fifo_rd_en (fifo_rd_en),
        .win_if       (win_if.master),
        .o_drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fall-through FIFO model; accepted writes form the expected byte stream
    assign fifo_empty = (f_cnt == 5'd0);
    assign fifo_full  = (f_cnt == 5'd16);
    assign fifo_dout  = mem[f_rd];

    always @(posedge clk) begin : fifo_model
        logic do_wr;
        logic do_rd;
        if (rst) begin
            f_cnt <= 5'd0;
            f_rd  <= 4'd0;
            f_wr  <= 4'd0;
        end else begin
            do_wr = rx_wr && !fifo_full;
            do_rd = fifo_rd_en && !fifo_empty;
            if (do_wr) begin
                mem[f_wr] <= wdata;
                f_wr      <= f_wr + 4'd1;
                exp_q.push_back(wdata);
            end
            if (do_rd) f_rd <= f_rd + 4'd1;
            f_cnt <= f_cnt + 5'(do_wr) - 5'(do_rd);
        end
    end

    // Collect bytes of every accepted window
    always @(posedge clk) begin : win_monitor
        if (!rst && win_if.win_valid && win_if.win_ready) begin
            for (int k = 0; k < 4; k++) begin
                if (k < int'(win_if.win_count)) got_q.push_back(win_if.win_data[k*8 +: 8]);
            end
            win_seen = win_seen + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_wr = 1'b1;
        wdata = b;
        @(negedge clk);
        rx_wr = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(win_if.win_valid), 32'd0);
        chk({tag, "_data"},  win_if.win_data,       32'd0);
        chk({tag, "_count"}, 32'(win_if.win_count), 32'd0);
        chk({tag, "_short"}, 32'(win_if.win_short), 32'd0);
        chk({tag, "_drop"},  32'(drop_cnt),         32'd0);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en),       32'd0);
    endtask

    initial begin : stim
        int seen0;
        int n;
        errors           = 0;
        checks           = 0;
        win_seen         = 0;
        rst              = 1'b1;
        rx_wr            = 1'b0;
        wdata            = 8'h00;
        win_if.win_ready = 1'b0;
        repeat (2) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // 1: full window, valid one cycle after the 4th pop
        win_if.win_ready = 1'b1;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("t1_valid_before", 32'(win_if.win_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(win_if.win_valid), 32'd1);
        chk("t1_data",  win_if.win_data,       32'h44332211);
        chk("t1_count", 32'(win_if.win_count), 32'd4);
        chk("t1_short", 32'(win_if.win_short), 32'd0);
        chk("t1_rd_en", 32'(fifo_rd_en),       32'd0);
        tick();
        chk("t1_accepted", 32'(win_if.win_valid), 32'd0);
        chk("t1_cleared",  win_if.win_data,       32'd0);

        // 2a: partial window flushed on the 8th idle cycle
        send(8'hA1); send(8'hB2);
        tick();
        repeat (7) tick();
        chk("t2_no_flush_yet", 32'(win_if.win_valid), 32'd0);
        tick();
        chk("t2_valid", 32'(win_if.win_valid), 32'd1);
        chk("t2_data",  win_if.win_data,       32'h0000B2A1);
        chk("t2_count", 32'(win_if.win_count), 32'd2);
        chk("t2_short", 32'(win_if.win_short), 32'd1);
        tick();
        chk("t2_short_clr", 32'(win_if.win_short), 32'd0);

        // 2b: pop in the threshold cycle suppresses the flush
        send(8'hC1); send(8'hD2);
        tick();
        repeat (6) tick();
        send(8'hE3);
        tick();
        chk("t2b_suppressed", 32'(win_if.win_valid), 32'd0);
        repeat (7) tick();
        chk("t2b_no_flush_yet", 32'(win_if.win_valid), 32'd0);
        tick();
        chk("t2b_valid", 32'(win_if.win_valid), 32'd1);
        chk("t2b_data",  win_if.win_data,       32'h00E3D2C1);
        chk("t2b_count", 32'(win_if.win_count), 32'd3);
        chk("t2b_short", 32'(win_if.win_short), 32'd1);
        tick();

        // 3: backpressure for 20 cycles with 12 bytes queued
        win_if.win_ready = 1'b0;
        exp_q.delete();
        got_q.delete();
        seen0 = win_seen;
        for (int i = 0; i < 12; i++) send(8'(8'h30 + i));
        for (int i = 0; i < 20; i++) begin
            chk("t3_hold_valid", 32'(win_if.win_valid), 32'd1);
            chk("t3_hold_data",  win_if.win_data,       32'h33323130);
            chk("t3_hold_rd_en", 32'(fifo_rd_en),       32'd0);
            tick();
        end
        win_if.win_ready = 1'b1;
        n = 0;
        while (got_q.size() < 12 && n < 60) begin
            tick();
            n++;
        end
        chk("t3_windows",  32'(win_seen - seen0), 32'd3);
        chk("t3_got_size", 32'(got_q.size()),     32'd12);
        chk("t3_exp_size", 32'(exp_q.size()),     32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < got_q.size()) chk("t3_byte", 32'(got_q[i]), 32'(8'h30 + i));
        end

        // 4: overflow counting and saturation
        win_if.win_ready = 1'b0;
        send(8'h40); send(8'h41); send(8'h42); send(8'h43);
        tick();
        chk("t4_present", 32'(win_if.win_valid), 32'd1);
        for (int i = 0; i < 20; i++) send(8'(8'h50 + i));
        chk("t4_drop",  32'(drop_cnt),   32'd4);
        chk("t4_full",  32'(fifo_full),  32'd1);
        chk("t4_rd_en", 32'(fifo_rd_en), 32'd0);
        force dut.u_drop_cnt.r_q = 16'hFFFE;
        #1;
        release dut.u_drop_cnt.r_q;
        chk("t4_forced", 32'(drop_cnt), 32'h0000FFFE);
        send(8'h60);
        chk("t4_sat_first", 32'(drop_cnt), 32'h0000FFFF);
        send(8'h61); send(8'h62);
        chk("t4_sat_hold", 32'(drop_cnt), 32'h0000FFFF);
        win_if.win_ready = 1'b1;
        repeat (40) tick();
        chk("t4_drained_valid", 32'(win_if.win_valid), 32'd0);
        chk("t4_drained_empty", 32'(fifo_empty),       32'd1);

        // 5: reset mid-window discards the partial window
        send(8'h55); send(8'h66);
        tick();
        rst = 1'b1;
        tick();
        chk_reset_outputs("t5_reset");
        rst = 1'b0;
        send(8'h77); send(8'h88); send(8'h99); send(8'hAA);
        tick();
        chk("t5_valid", 32'(win_if.win_valid), 32'd1);
        chk("t5_data",  win_if.win_data,       32'hAA998877);
        chk("t5_count", 32'(win_if.win_count), 32'd4);
        chk("t5_short", 32'(win_if.win_short), 32'd0);
        tick();

        // 6: random bytes, gaps and ready against the accepted-write stream
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 400; i++) begin
            rx_wr            = ($urandom_range(0, 99) < 45);
            wdata            = 8'($urandom);
            win_if.win_ready = ($urandom_range(0, 99) < 60);
            tick();
        end
        rx_wr            = 1'b0;
        win_if.win_ready = 1'b1;
        n = 0;
        while (!(fifo_empty && got_q.size() == exp_q.size()) && n < 200) begin
            tick();
            n++;
        end
        chk("t6_drained", 32'(fifo_empty && got_q.size() == exp_q.size()), 32'd1);
        chk("t6_size",    32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk("t6_byte", 32'(got_q[i]), 32'(exp_q[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rx_window_ctrl
